// File: rtl/inv_ark_mix_columns.sv
// Decrypt-round stage: AddRoundKey on the InvSubBytes result, then column-serial
// InvMixColumns (skippable for the final round), with a valid/ready handshake on both sides.
module inv_ark_mix_columns #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] IN_DATA,
  input  logic [127:0] ROUND_KEY,
  input  logic         skip_mix,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] OUT_DATA
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_ark_mix_columns: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    MIX,
    DONE
  } state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [1:0]   r_col;
  logic [127:0] r_work;
  logic [127:0] w_mixed;
  logic         w_last;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 09/0b/0d/0e are all built from the shared x, 2x, 4x, 8x chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int unsigned k = 0; k < 4; k++) begin
      a[k]  = c[31 - 8*k -: 8];
      m2[k] = xt(a[k]);
      m4[k] = xt(m2[k]);
      m8[k] = xt(m4[k]);
      m9[k] = m8[k] ^ a[k];
      mb[k] = m8[k] ^ m2[k] ^ a[k];
      md[k] = m8[k] ^ m4[k] ^ a[k];
      me[k] = m8[k] ^ m4[k] ^ m2[k];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // r_col is always a multiple of COLS_PER_CYCLE, so r_col + i never passes column 3.
  always_comb begin
    w_mixed = r_work;
    for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
      w_mixed[32*(3 - i - 32'(r_col)) +: 32] = inv_mix_col(r_work[32*(3 - i - 32'(r_col)) +: 32]);
    end
  end

  assign w_last = ({1'b0, r_col} + 3'(COLS_PER_CYCLE)) == 3'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = skip_mix ? DONE : MIX;
      MIX:     if (w_last) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_col  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work <= IN_DATA ^ ROUND_KEY;
            r_col  <= '0;
          end
        end
        MIX: begin
          r_work <= w_mixed;
          r_col  <= r_col + 2'(COLS_PER_CYCLE);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign OUT_DATA  = r_work;

endmodule

// File: tb/tb_inv_ark_mix_columns.sv
// Bench for inv_ark_mix_columns: three instances (1, 2, 4 columns per cycle) share stimulus
// and are checked against a GF(2^8) matrix reference model.
module tb_inv_ark_mix_columns;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic         skip_mix;
  logic [127:0] in_data;
  logic [127:0] round_key;
  logic         in_rdy  [3];
  logic         out_vld [3];
  logic [127:0] out_dat [3];

  int unsigned  cpc [3] = '{1, 2, 4};
  int           n_checks = 0;
  int           n_pass   = 0;

  always #5 clk = ~clk;

  inv_ark_mix_columns #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .IN_DATA(in_data), .ROUND_KEY(round_key), .skip_mix(skip_mix),
    .out_valid(out_vld[0]), .out_ready(out_ready), .OUT_DATA(out_dat[0])
  );
  inv_ark_mix_columns #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .IN_DATA(in_data), .ROUND_KEY(round_key), .skip_mix(skip_mix),
    .out_valid(out_vld[1]), .out_ready(out_ready), .OUT_DATA(out_dat[1])
  );
  inv_ark_mix_columns #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[2]),
    .IN_DATA(in_data), .ROUND_KEY(round_key), .skip_mix(skip_mix),
    .out_valid(out_vld[2]), .out_ready(out_ready), .OUT_DATA(out_dat[2])
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Generic shift-and-add multiply with reduction by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011b << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_inv_mix(input logic [127:0] s);
    logic [7:0]   coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [127:0] res = '0;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(coef[(k - r + 4) % 4], s[127 - 8*(4*c + k) -: 8]);
        res[127 - 8*(4*c + r) -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at posedge+1 with all instances idle.
  task automatic xfer(input logic [127:0] d, input logic [127:0] k, input logic s,
                      input logic [127:0] exp, input int hold);
    int lat [3];
    bit seen [3];
    int n;
    for (int j = 0; j < 3; j++) begin
      check_eq($sformatf("in_ready_idle[%0d]", cpc[j]), 128'(in_rdy[j]), 128'd1);
      seen[j] = 1'b0;
      lat[j]  = 0;
    end
    in_data = d; round_key = k; skip_mix = s; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after the accepting edge: the in-flight result must not change.
    in_valid = 1'b0; in_data = rand128(); round_key = rand128(); skip_mix = 1'($urandom);
    for (n = 1; n <= 12; n++) begin
      for (int j = 0; j < 3; j++) if (!seen[j] && out_vld[j]) begin seen[j] = 1'b1; lat[j] = n; end
      if (seen[0] && seen[1] && seen[2]) break;
      @(posedge clk); #1;
    end
    for (int j = 0; j < 3; j++) begin
      check_eq($sformatf("latency[%0d]", cpc[j]), 128'(lat[j]), s ? 128'd1 : 128'(4 / cpc[j] + 1));
      check_eq($sformatf("out_data[%0d]", cpc[j]), out_dat[j], exp);
      check_eq($sformatf("in_ready_done[%0d]", cpc[j]), 128'(in_rdy[j]), 128'd0);
    end
    repeat (hold) begin
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++) begin
        check_eq($sformatf("hold_valid[%0d]", cpc[j]), 128'(out_vld[j]), 128'd1);
        check_eq($sformatf("hold_data[%0d]", cpc[j]), out_dat[j], exp);
        check_eq($sformatf("hold_in_ready[%0d]", cpc[j]), 128'(in_rdy[j]), 128'd0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check_eq($sformatf("release_valid[%0d]", cpc[j]), 128'(out_vld[j]), 128'd0);
      check_eq($sformatf("release_in_ready[%0d]", cpc[j]), 128'(in_rdy[j]), 128'd1);
    end
  endtask

  localparam logic [127:0] C1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] C1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

  initial begin
    logic [127:0] d, k, x;
    logic         s;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; skip_mix = 1'b0;
    in_data = '0; round_key = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      check_eq($sformatf("rst_in_ready[%0d]", cpc[j]), 128'(in_rdy[j]), 128'd0);
      check_eq($sformatf("rst_out_valid[%0d]", cpc[j]), 128'(out_vld[j]), 128'd0);
      check_eq($sformatf("rst_out_data[%0d]", cpc[j]), out_dat[j], 128'd0);
    end
    rst = 1'b0;
    #1;

    xfer(C1_IN, 128'd0, 1'b0, C1_OUT, 0);
    xfer(128'd0, 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d, 1'b0,
         128'hd4d4d4d5_2d26314c_db135345_f20a225c, 1);
    d = 128'h00112233_44556677_8899aabb_ccddeeff;
    k = 128'h13111d7f_e3944a17_f307a78b_4d2b30c5;
    xfer(d, k, 1'b1, d ^ k, 0);
    xfer(C1_IN, 128'd0, 1'b0, C1_OUT, 10);

    // Reset while in flight: result discarded, then a fresh transfer completes.
    in_data = C1_IN; round_key = '0; skip_mix = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      check_eq($sformatf("midrst_out_valid[%0d]", cpc[j]), 128'(out_vld[j]), 128'd0);
      check_eq($sformatf("midrst_out_data[%0d]", cpc[j]), out_dat[j], 128'd0);
      check_eq($sformatf("midrst_in_ready[%0d]", cpc[j]), 128'(in_rdy[j]), 128'd0);
    end
    rst = 1'b0;
    #1;
    xfer(C1_IN, 128'd0, 1'b0, C1_OUT, 0);

    for (int t = 0; t < 12; t++) begin
      d = rand128();
      k = rand128();
      s = ($urandom_range(0, 3) == 0);
      x = d ^ k;
      xfer(d, k, s, s ? x : ref_inv_mix(x), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
